// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter with burst lock feeding a fixed-latency tagged shift pipeline.
// Beats are admitted one per cycle and emerge SIZE cycles later with their source id.
module fifo_rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SIZE  = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ-1:0]         req_last,
  input  logic [N_REQ*WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [ID_W-1:0]          out_id,
  output logic                     out_last,
  output logic                     busy
);

  typedef enum logic {
    ARB_OPEN,
    ARB_LOCKED
  } arb_state_e;

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   owner_q, owner_d;

  logic              xfer;
  int unsigned       win_idx;
  logic [WIDTH-1:0]  win_data;
  logic              win_last;
  logic [N_REQ-1:0]  rot_valid;

  logic [SIZE-1:0]   vld_q, vld_d;
  logic [SIZE-1:0]   lst_q, lst_d;
  logic [WIDTH-1:0]  dat_q [SIZE];
  logic [WIDTH-1:0]  dat_d [SIZE];
  logic [ID_W-1:0]   id_q  [SIZE];
  logic [ID_W-1:0]   id_d  [SIZE];

  // Grant logic: uses only valid/state/ptr/owner so ready never depends on data or last.
  always_comb begin
    xfer      = 1'b0;
    win_idx   = 0;
    rot_valid = N_REQ'({req_valid, req_valid} >> ptr_q);
    if (state_q == ARB_LOCKED) begin
      win_idx = 32'(owner_q);
      xfer    = |(req_valid & (N_REQ'(1) << owner_q));
    end else begin
      // Scan downwards so the position closest to ptr is the one left standing.
      for (int unsigned k = N_REQ; k > 0; k--) begin
        if (rot_valid[k-1]) begin
          xfer    = 1'b1;
          win_idx = (32'(ptr_q) + k - 1) % N_REQ;
        end
      end
    end
    if (reset) begin
      xfer = 1'b0;
    end
    req_ready = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      req_ready[j] = xfer && (win_idx == j);
    end
    win_data = WIDTH'(req_data >> (win_idx * WIDTH));
    win_last = |(req_last & (N_REQ'(1) << win_idx));
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    if (xfer) begin
      if (win_last) begin
        state_d = ARB_OPEN;
        ptr_d   = ID_W'((win_idx + 1) % N_REQ);
      end else begin
        state_d = ARB_LOCKED;
        owner_d = ID_W'(win_idx);
      end
    end
  end

  always_comb begin
    vld_d[0] = xfer;
    lst_d[0] = win_last;
    dat_d[0] = win_data;
    id_d[0]  = ID_W'(win_idx);
    for (int unsigned s = 1; s < SIZE; s++) begin
      vld_d[s] = vld_q[s-1];
      lst_d[s] = lst_q[s-1];
      dat_d[s] = dat_q[s-1];
      id_d[s]  = id_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_OPEN;
      ptr_q   <= '0;
      owner_q <= '0;
      vld_q   <= '0;
      lst_q   <= '0;
      for (int unsigned s = 0; s < SIZE; s++) begin
        dat_q[s] <= '0;
        id_q[s]  <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      vld_q   <= vld_d;
      lst_q   <= lst_d;
      for (int unsigned s = 0; s < SIZE; s++) begin
        dat_q[s] <= dat_d[s];
        id_q[s]  <= id_d[s];
      end
    end
  end

  assign out_valid = vld_q[SIZE-1];
  assign out_last  = lst_q[SIZE-1];
  assign out_data  = dat_q[SIZE-1];
  assign out_id    = id_q[SIZE-1];
  assign busy      = (state_q == ARB_LOCKED) || (|vld_q);

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench: vector table for the 4-requester SIZE=4 instance, plus a
// hand-written sequence for a 3-requester SIZE=1 instance (wrap and minimum depth).
module tb_fifo_rr_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid, req_last, req_ready;
  logic [31:0] req_data;
  logic        out_valid, out_last, busy;
  logic [7:0]  out_data;
  logic [1:0]  out_id;

  logic        rst1;
  logic [2:0]  r1_valid, r1_last, r1_ready;
  logic [23:0] r1_data;
  logic        o1_valid, o1_last, busy1;
  logic [7:0]  o1_data;
  logic [1:0]  o1_id;

  int n_checks;
  int n_errors;

  fifo_rr_arbiter #(.N_REQ(4), .WIDTH(8), .SIZE(4), .ID_W(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .out_valid(out_valid),
    .out_data(out_data), .out_id(out_id), .out_last(out_last), .busy(busy)
  );

  fifo_rr_arbiter #(.N_REQ(3), .WIDTH(8), .SIZE(1), .ID_W(2)) dut1 (
    .clk(clk), .reset(rst1), .req_valid(r1_valid), .req_last(r1_last),
    .req_data(r1_data), .req_ready(r1_ready), .out_valid(o1_valid),
    .out_data(o1_data), .out_id(o1_id), .out_last(o1_last), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  // m: 0 = ready only, 1 = also valid/busy (payload when ov), 2 = full payload incl. zeros
  typedef struct {
    logic        rst;
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    logic [3:0]  rdy;
    int          m;
    logic        ov;
    logic [7:0]  od;
    logic [1:0]  oid;
    logic        ol;
    logic        bsy;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic [3:0] v, input logic [3:0] l,
                     input logic [31:0] d, input logic [3:0] rdy, input int m,
                     input logic ov, input logic [7:0] od, input logic [1:0] oid,
                     input logic ol, input logic bsy);
    vec_t e;
    e.rst = r; e.v = v; e.l = l; e.d = d; e.rdy = rdy; e.m = m;
    e.ov = ov; e.od = od; e.oid = oid; e.ol = ol; e.bsy = bsy;
    vq.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step1(input logic [2:0] v, input logic [23:0] d, input logic [2:0] rdy,
                       input logic ov, input logic [7:0] od, input logic [1:0] oid,
                       input logic bsy, input string tag);
    @(negedge clk);
    rst1 = 1'b0; r1_valid = v; r1_last = 3'b111; r1_data = d;
    #1;
    check({tag, " ready"}, 32'(r1_ready), 32'(rdy));
    check({tag, " out_valid"}, 32'(o1_valid), 32'(ov));
    check({tag, " busy"}, 32'(busy1), 32'(bsy));
    if (ov) begin
      check({tag, " out_data"}, 32'(o1_data), 32'(od));
      check({tag, " out_id"}, 32'(o1_id), 32'(oid));
      check({tag, " out_last"}, 32'(o1_last), 32'(1'b1));
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1; req_valid = '0; req_last = '0; req_data = '0;
    rst1 = 1'b1; r1_valid = '0; r1_last = '0; r1_data = '0;

    // reset and idle
    add(1'b1, 4'hF, 4'hF, 32'h0, 4'h0, 0, 1'b0, 8'h0, 2'd0, 1'b0, 1'b0);
    add(1'b1, 4'h0, 4'h0, 32'h0, 4'h0, 2, 1'b0, 8'h0, 2'd0, 1'b0, 1'b0);
    add(1'b0, 4'h0, 4'h0, 32'h0, 4'h0, 2, 1'b0, 8'h0, 2'd0, 1'b0, 1'b0);
    add(1'b0, 4'h0, 4'h0, 32'h0, 4'h0, 1, 1'b0, 8'h0, 2'd0, 1'b0, 1'b0);
    // fairness: all valid, single-beat bursts
    for (int k = 0; k < 8; k++)
      add(1'b0, 4'hF, 4'hF, 32'hC3C2C1C0, 4'(1 << (k % 4)), 1,
          k >= 4, 8'(8'hC0 + k % 4), 2'(k % 4), 1'b1, k != 0);
    for (int k = 0; k < 4; k++)
      add(1'b0, 4'h0, 4'h0, 32'h0, 4'h0, 1, 1'b1, 8'(8'hC0 + k), 2'(k), 1'b1, 1'b1);
    add(1'b0, 4'h0, 4'h0, 32'h0, 4'h0, 1, 1'b0, 8'h0, 2'd0, 1'b0, 1'b0);
    // single request from req 2
    add(1'b0, 4'b0100, 4'b0100, 32'h005A0000, 4'b0100, 1, 1'b0, 8'h0, 2'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++)
      add(1'b0, 4'h0, 4'h0, 32'h0, 4'h0, 1, 1'b0, 8'h0, 2'd0, 1'b0, 1'b1);
    add(1'b0, 4'h0, 4'h0, 32'h0, 4'h0, 1, 1'b1, 8'h5A, 2'd2, 1'b1, 1'b1);
    add(1'b0, 4'h0, 4'h0, 32'h0, 4'h0, 1, 1'b0, 8'h0, 2'd0, 1'b0, 1'b0);
    // burst lock: req 1 three beats with a gap, req 0/3 contending (ptr starts at 3)
    add(1'b0, 4'b0010, 4'b0000, 32'h00001100, 4'b0010, 1, 1'b0, 8'h0, 2'd0, 1'b0, 1'b0);
    add(1'b0, 4'b1011, 4'b0000, 32'h33001200, 4'b0010, 1, 1'b0, 8'h0, 2'd0, 1'b0, 1'b1);
    add(1'b0, 4'b1001, 4'b0000, 32'h33000000, 4'b0000, 1, 1'b0, 8'h0, 2'd0, 1'b0, 1'b1);
    add(1'b0, 4'b1011, 4'b0010, 32'h33001300, 4'b0010, 1, 1'b0, 8'h0, 2'd0, 1'b0, 1'b1);
    add(1'b0, 4'b1001, 4'b1001, 32'h33000030, 4'b1000, 1, 1'b1, 8'h11, 2'd1, 1'b0, 1'b1);
    add(1'b0, 4'b1001, 4'b1001, 32'h33000030, 4'b0001, 1, 1'b1, 8'h12, 2'd1, 1'b0, 1'b1);
    add(1'b0, 4'h0, 4'h0, 32'h0, 4'h0, 1, 1'b0, 8'h0, 2'd0, 1'b0, 1'b1);
    add(1'b0, 4'h0, 4'h0, 32'h0, 4'h0, 1, 1'b1, 8'h13, 2'd1, 1'b1, 1'b1);
    add(1'b0, 4'h0, 4'h0, 32'h0, 4'h0, 1, 1'b1, 8'h33, 2'd3, 1'b1, 1'b1);
    add(1'b0, 4'h0, 4'h0, 32'h0, 4'h0, 1, 1'b1, 8'h30, 2'd0, 1'b1, 1'b1);
    add(1'b0, 4'h0, 4'h0, 32'h0, 4'h0, 1, 1'b0, 8'h0, 2'd0, 1'b0, 1'b0);
    // reset while req 3 is locked with two beats in flight (ptr = 1 here)
    add(1'b0, 4'b1000, 4'b0000, 32'hD0000000, 4'b1000, 1, 1'b0, 8'h0, 2'd0, 1'b0, 1'b0);
    add(1'b0, 4'b1000, 4'b0000, 32'hD1000000, 4'b1000, 1, 1'b0, 8'h0, 2'd0, 1'b0, 1'b1);
    add(1'b1, 4'b1001, 4'b0000, 32'hD2000000, 4'b0000, 1, 1'b0, 8'h0, 2'd0, 1'b0, 1'b1);
    add(1'b0, 4'b1001, 4'b1001, 32'hD3000040, 4'b0001, 2, 1'b0, 8'h0, 2'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++)
      add(1'b0, 4'h0, 4'h0, 32'h0, 4'h0, 1, 1'b0, 8'h0, 2'd0, 1'b0, 1'b1);
    add(1'b0, 4'h0, 4'h0, 32'h0, 4'h0, 1, 1'b1, 8'h40, 2'd0, 1'b1, 1'b1);
    add(1'b0, 4'h0, 4'h0, 32'h0, 4'h0, 1, 1'b0, 8'h0, 2'd0, 1'b0, 1'b0);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      reset = vq[i].rst; req_valid = vq[i].v; req_last = vq[i].l; req_data = vq[i].d;
      #1;
      check($sformatf("v%0d ready", i), 32'(req_ready), 32'(vq[i].rdy));
      if (vq[i].m >= 1) begin
        check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vq[i].ov));
        check($sformatf("v%0d busy", i), 32'(busy), 32'(vq[i].bsy));
        if (vq[i].m == 2 || vq[i].ov) begin
          check($sformatf("v%0d out_data", i), 32'(out_data), 32'(vq[i].od));
          check($sformatf("v%0d out_id", i), 32'(out_id), 32'(vq[i].oid));
          check($sformatf("v%0d out_last", i), 32'(out_last), 32'(vq[i].ol));
        end
      end
    end

    // SIZE=1, N_REQ=3: each beat visible the cycle after acceptance, ptr wraps 2 -> 0
    step1(3'b001, 24'h0000A0, 3'b001, 1'b0, 8'h00, 2'd0, 1'b0, "s1 a");
    check("s1 reset out_data", 32'(o1_data), 32'h0);
    step1(3'b010, 24'h00B100, 3'b010, 1'b1, 8'hA0, 2'd0, 1'b1, "s1 b");
    step1(3'b111, 24'hC2C1C0, 3'b100, 1'b1, 8'hB1, 2'd1, 1'b1, "s1 c");
    step1(3'b111, 24'hC2C1C0, 3'b001, 1'b1, 8'hC2, 2'd2, 1'b1, "s1 d");
    step1(3'b000, 24'h000000, 3'b000, 1'b1, 8'hC0, 2'd0, 1'b1, "s1 e");
    step1(3'b000, 24'h000000, 3'b000, 1'b0, 8'h00, 2'd0, 1'b0, "s1 f");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_rr_arbiter.md
# fifo_rr_arbiter

- Shares one fixed-latency `fifo_buffer`-style delay line between `N_REQ` requesters.
- Each cycle, a round-robin arbiter with burst lock admits at most one beat from a requester.
- The admitted beat is tagged with its source id and travels through a `SIZE`-deep shift pipeline.
- Used where several near-data units feed one skew/delay stage and the consumer must demultiplex by id.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (≥2)
- `WIDTH`, 8, data bits per beat
- `SIZE`, 4, pipeline depth in stages (≥1)
- `ID_W`, 2, id width; must satisfy 2^`ID_W` ≥ `N_REQ`

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  `N_REQ`  per-requester beat valid
- `req_last`  in  `N_REQ`  per-requester end-of-burst marker
- `req_data`  in  `N_REQ*WIDTH`  requester i occupies bits [i*WIDTH +: WIDTH]
- `req_ready`  out  `N_REQ`  combinational grant, at most one bit high
- `out_valid`  out  1  pipeline output valid
- `out_data`  out  `WIDTH`  delayed beat
- `out_id`  out  `ID_W`  source requester of `out_data`
- `out_last`  out  1  delayed `req_last`
- `busy`  out  1  burst locked or any beat in flight

## Operation
- **Transfer:** a beat transfers on edge t when `req_valid[i]` and `req_ready[i]` are both high.
- **State:** `ptr` (`ID_W` bits, next highest-priority requester), `lock` (1 bit), `owner` (`ID_W` bits).
- **Arbitration when `lock`=0:**
  - Scan i = `ptr`, `ptr`+1, … modulo `N_REQ`.
  - The first i with `req_valid[i]` gets `req_ready[i]`=1; all other ready bits are 0.
  - No valid requesters means no grant.
- **Arbitration when `lock`=1:**
  - `req_ready[owner]` = `req_valid[owner]`; all other ready bits are 0.
  - An owner with valid low stalls the burst. The lock holds, and no other requester may enter.
- **Burst end:**
  - On a transfer with `req_last`=1: `lock`←0, `ptr`←(winner+1) mod `N_REQ`.
  - On a transfer with `req_last`=0: `lock`←1, `owner`←winner, `ptr` unchanged.
- **Single-beat bursts** (`last`=1 on the first beat) never set `lock`.
- **`req_ready` dependencies:** depends only on `req_valid`, `lock`, `owner` and `ptr`. It must never depend on `req_data` or `req_last`.
- **Pipeline:**
  - `SIZE` register stages of {valid, data, id, last}.
  - Stage 0 loads the transferred beat, or valid=0 when no transfer occurs.
  - Every stage shifts every cycle. There is no backpressure, and the consumer must always accept.
  - `out_*` come from the last stage.
- **Data on invalid stages:** `data`/`id`/`last` hold whatever was shifted in. Checkers must qualify them with `out_valid`.
- **`busy`** = `lock` OR any stage valid. This is combinational from the registers.
- **Reset** (synchronous, dominant over a simultaneous transfer):
  - `ptr`=0, `lock`=0, `owner`=0.
  - All stage valid/data/id/last cleared to 0, so `out_valid`=0, `out_data`=0, `out_id`=0, `out_last`=0, `busy`=0.
  - `req_ready`=0 while `reset` is high.
  - Reset mid-burst or with beats in flight discards them. No partial output appears afterwards.

## Timing
- **Output latency:** a beat accepted at edge t appears on `out_*` after edge t+`SIZE`-1 and stays for exactly one cycle.
  - With `SIZE`=1, it is visible in the cycle after acceptance.
- **Throughput:** one beat per cycle sustained, including back-to-back beats from different requesters.
- **Grant timing:** same-cycle combinational grant, with zero-cycle arbitration latency.
- **Priority update:** takes effect on the cycle after the burst's last beat.
- **Wrap:** `ptr` wraps from `N_REQ`-1 to 0. For non-power-of-2 `N_REQ`, `ptr` never takes values ≥ `N_REQ`.
- **`busy` timing:** falls in the cycle after the final in-flight beat leaves the last stage, provided `lock`=0.

## Test plan
- **Reset then idle:** `SIZE`=4, hold all `req_valid`=0 after reset.
  - `out_valid`=0, `busy`=0 and `req_ready`=0 throughout.
- **Single request:** req 2 sends data 0x5A with last=1 at edge t.
  - `req_ready`=4'b0100.
  - `out_valid`=1, `out_data`=0x5A, `out_id`=2, `out_last`=1 after edge t+3, for one cycle only.
- **Fairness:** all four requesters hold valid with last=1 continuously for 8 cycles.
  - Grant order is 0,1,2,3,0,1,2,3.
  - `out_id` shows the same order, 4 cycles later, with no bubbles.
- **Burst lock:** req 1 sends a 3-beat burst (0x11, 0x12, 0x13 last), with a 1-cycle valid gap after beat 2, while req 0 and req 3 stay valid.
  - Only req 1 is granted until 0x13 transfers.
  - During the gap, no grant is given and a bubble appears in the output.
  - Next grant goes to req 3 (`ptr`=2, req 2 idle), then req 0.
- **Reset mid-operation:** assert reset while req 3 is locked mid-burst with 2 beats in flight.
  - After the reset edge: `out_valid`=0, `busy`=0, `ptr`=0.
  - Next contention between req 0 and req 3 grants req 0.
- **`SIZE`=1 variant:** back-to-back beats 0xA0 (req 0) and 0xB1 (req 1).
  - Appear on consecutive cycles, each in the cycle right after its acceptance edge.
